freq_meter_50mhz: RTL
=====================

FREQ_METER_50MHZ -- requirements
Module: freq_meter_50mhz

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000; gate window length in clock50 cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter WIDTH, default 16; width of the frequency result in Hz (edges per window).
REQ-003 SHALL have port clock50  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  measurement enable, level-sensitive, synchronous to clock50.
REQ-006 SHALL have port sig_in  input  1  slow signal under measurement, asynchronous to clock50.
REQ-007 SHALL have port freq  output  WIDTH  rising edges counted in the last completed window.
REQ-008 SHALL have port valid  output  1  one-cycle pulse, asserted in the cycle freq takes a new value.
REQ-009 SHALL have port overflow  output  1  edge count of the last completed window exceeded 2^WIDTH-1.

Function
REQ-010 SHALL pass sig_in through a two-flop synchronizer (s1, s2), plus a third flop (s3) for edge detection.
REQ-011 SHALL define rise = s2 & ~s3; a sig_in rising edge produces rise 2-3 cycles later, once per edge, with no debounce.
REQ-012 SHALL implement states IDLE and MEASURE.
REQ-013 IDLE -> MEASURE SHALL occur on the cycle en=1 is sampled; gate counter and edge counter SHALL load 0 on that transition.
REQ-014 MEASURE -> IDLE SHALL occur on the cycle en=0 is sampled; the partial count SHALL be discarded; freq and overflow SHALL hold; valid SHALL stay 0.
REQ-015 In MEASURE, the gate counter SHALL count 0 .. GATE_CYCLES-1 and wrap to 0; the wrap cycle is the window end.
REQ-016 In MEASURE, the edge counter SHALL increment by 1 on each cycle with rise=1.
REQ-017 At window end, total = edge counter + rise (this cycle).
REQ-018 At window end, freq SHALL load min(total, 2^WIDTH-1).
REQ-019 At window end, overflow SHALL load (total > 2^WIDTH-1), and valid SHALL be 1 for exactly the following cycle.
REQ-020 At window end, the edge counter SHALL reset to 0; the next window SHALL start with no dead cycle.
REQ-021 The edge counter SHALL saturate at 2^WIDTH and never wrap within a window.
REQ-022 Edges whose rise falls after the window-end cycle SHALL count in the next window (synchronizer latency accepted).
REQ-023 Windows SHALL repeat back-to-back while en=1; valid SHALL pulse exactly every GATE_CYCLES cycles.
REQ-024 In IDLE, rise SHALL be ignored and the synchronizer SHALL keep running.

Reset
REQ-025 When reset=1, it SHALL take priority over en and all other events.
REQ-026 Reset SHALL force state=IDLE, zero both counters, and clear s1, s2, s3.
REQ-027 Reset SHALL force freq=0, valid=0, overflow=0.
REQ-028 Reset mid-window SHALL discard the partial count with no valid pulse.
REQ-029 A sig_in held high across reset release SHALL register as one rising edge ~2 cycles later, counted only if in MEASURE then.

Verification (GATE_CYCLES=100, WIDTH=16 unless stated)
REQ-030 en=1, sig_in square wave of period 10 cycles -> valid pulses at 100-cycle spacing; every window after the first gives freq=10, overflow=0.
REQ-031 en=1, sig_in constant 0 -> freq=0, valid still pulses every 100 cycles.
REQ-032 WIDTH=4, sig_in period 4 cycles -> 25 edges/window -> freq=15, overflow=1; then period 10 -> next full window freq=10, overflow=0.
REQ-033 en dropped at cycle 50 of a window, re-raised 20 cycles later -> no valid for the aborted window; freq holds its old value; next valid 100 cycles after re-entry.
REQ-034 reset pulsed at cycle 60 of a window with en=1 -> freq=0, valid=0, overflow=0 next cycle; first new valid 100 cycles after MEASURE re-entry.
REQ-035 Single sig_in edge placed so rise lands exactly on the window-end cycle -> counted in that window's freq, not the next.

Source files
------------

// File: rtl/freq_meter_50mhz.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over fixed
// back-to-back windows of GATE_CYCLES clock50 cycles and reports the saturated total.
module freq_meter_50mhz #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned WIDTH       = 16
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] freq,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH:0]   EDGE_SAT  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH+1:0] FREQ_MAX  = {2'b00, {WIDTH{1'b1}}};

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [0:0]       state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [WIDTH:0]   edge_q, edge_d;
  logic [WIDTH-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic [WIDTH+1:0] total;
  logic             total_ovf;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;

    rise      = s2_q & ~s3_q;
    // The edge seen in the window-end cycle still belongs to the closing window.
    total     = {1'b0, edge_q} + {{(WIDTH+1){1'b0}}, rise};
    total_ovf = (total > FREQ_MAX);

    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
          gate_d  = '0;
          edge_d  = '0;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
          gate_d  = '0;
          edge_d  = '0;
        end else if (gate_q == GATE_LAST) begin
          gate_d  = '0;
          edge_d  = '0;
          valid_d = 1'b1;
          ovf_d   = total_ovf;
          freq_d  = total_ovf ? '1 : total[WIDTH-1:0];
        end else begin
          gate_d = gate_q + GW'(1);
          // One count above the output range is enough to flag overflow.
          if (rise && (edge_q != EDGE_SAT)) begin
            edge_d = edge_q + (WIDTH+1)'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gate_d  = '0;
        edge_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule
